// File: rtl/mealy_moore_1011.sv
// ============================================================================
// mealy_moore_1011
// ----------------------------------------------------------------------------
// Purpose:
//   Two independent overlapping detectors for the serial pattern 1011, one
//   built as a Mealy machine and one as a Moore machine. Both share the same
//   clock, reset and serial input so their outputs can be compared directly.
//
//   Mealy machine: states M0 (idle), M1 ("1"), M2 ("10"), M3 ("101"), 2-bit
//   binary. Its flag is raised in the same cycle the 4th bit is on 'in'.
//
//   Moore machine: states S0..S4, 3-bit binary, S4 meaning "1011 seen". Its
//   flag depends on state only, so it is high for the cycle after the edge
//   that sampled the 4th bit.
//
//   Both detectors allow overlap: the trailing 1 of a match is reused as the
//   leading 1 of the next match (1011011 gives two detections).
//
// Configuration macro:
//   MEALY_REG_OUT_EN - when defined, mealy_out comes from a flop loaded each
//                      edge with (state == M3 && in), which makes it
//                      cycle-identical to moore_out. When undefined (the
//                      default build), mealy_out is purely combinational.
//
// Ports:
//   clk        in  1  clock, all state updates on the rising edge
//   rst        in  1  asynchronous reset, active low (0 = reset, 1 = run)
//   in         in  1  serial data bit, sampled on the rising edge
//   mealy_out  out 1  detection flag from the Mealy machine
//   moore_out  out 1  detection flag from the Moore machine
// ============================================================================
module mealy_moore_1011 (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic mealy_out,
    output logic moore_out
);

    // ------------------------------------------------------------------------
    // State encodings
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        M0 = 2'd0,
        M1 = 2'd1,
        M2 = 2'd2,
        M3 = 2'd3
    } mealy_state_e;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } moore_state_e;

    mealy_state_e mealy_state_q;
    mealy_state_e mealy_state_d;
    moore_state_e moore_state_q;
    moore_state_e moore_state_d;

    // Raw Mealy detection term: "101" already seen and the 4th bit is a 1.
    logic mealy_hit;

    // ------------------------------------------------------------------------
    // Mealy machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mealy_state_q <= M0;
        end else begin
            mealy_state_q <= mealy_state_d;
        end
    end

    // After a match (M3 with in=1) the trailing 1 is kept by going to M1,
    // which is what gives overlapping detection. M3 with in=0 keeps "10".
    always_comb begin
        mealy_state_d = M0;
        case (mealy_state_q)
            M0:      mealy_state_d = in ? M1 : M0;
            M1:      mealy_state_d = in ? M1 : M2;
            M2:      mealy_state_d = in ? M3 : M0;
            M3:      mealy_state_d = in ? M1 : M2;
            default: mealy_state_d = M0;
        endcase
    end

    assign mealy_hit = (mealy_state_q == M3) && in;

    // ------------------------------------------------------------------------
    // Moore machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            moore_state_q <= S0;
        end else begin
            moore_state_q <= moore_state_d;
        end
    end

    // S4 behaves like "1" for the overlap case (in=1 -> S1) and like "10"
    // when followed by a 0 (in=0 -> S2). The three unused codes fall through
    // to the default and recover to S0 on the next edge.
    always_comb begin
        moore_state_d = S0;
        case (moore_state_q)
            S0:      moore_state_d = in ? S1 : S0;
            S1:      moore_state_d = in ? S1 : S2;
            S2:      moore_state_d = in ? S3 : S0;
            S3:      moore_state_d = in ? S4 : S2;
            S4:      moore_state_d = in ? S1 : S2;
            default: moore_state_d = S0;
        endcase
    end

    assign moore_out = (moore_state_q == S4);

    // ------------------------------------------------------------------------
    // Mealy output stage
    // ------------------------------------------------------------------------
`ifdef MEALY_REG_OUT_EN
    logic mealy_out_q;
    logic mealy_out_d;

    assign mealy_out_d = mealy_hit;

    // Registering the hit term delays it by exactly one edge, lining it up
    // with the Moore flag and removing the combinational path from 'in'.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mealy_out_q <= 1'b0;
        end else begin
            mealy_out_q <= mealy_out_d;
        end
    end

    assign mealy_out = mealy_out_q;
`else
    assign mealy_out = mealy_hit;
`endif

endmodule

// File: tb/tb_mealy_moore_1011.sv
// ============================================================================
// tb_mealy_moore_1011
// ----------------------------------------------------------------------------
// Directed bench for mealy_moore_1011. Each serial bit is driven just after a
// falling edge and the outputs are sampled shortly afterwards, in the middle
// of the cycle whose rising edge will sample that bit. Expected values are
// hand-derived per step: the combinational Mealy flag is high in the cycle of
// the 4th bit, the Moore flag in the following cycle. With MEALY_REG_OUT_EN
// defined, the expected Mealy flag equals the expected Moore flag.
// ============================================================================
module tb_mealy_moore_1011;

    logic clk;
    logic rst;
    logic in;
    logic mealy_out;
    logic moore_out;

    int checks;
    int failures;

    mealy_moore_1011 dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .mealy_out (mealy_out),
        .moore_out (moore_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected Mealy flag for the current build.
    function automatic logic expMealy(input logic combExp, input logic mooreExp);
`ifdef MEALY_REG_OUT_EN
        return mooreExp;
`else
        return combExp;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drive one serial bit for one clock cycle and check both flags mid-cycle.
    task automatic applyStimulus(input string tag, input logic bitVal,
                                 input logic mealyComb, input logic mooreExp);
        @(negedge clk);
        in = bitVal;
        #1;
        checkOutput({tag, ".mealy"}, mealy_out, expMealy(mealyComb, mooreExp));
        checkOutput({tag, ".moore"}, moore_out, mooreExp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        in       = 1'b1;

        // Reset held with in=1 while clocks run: both flags stay low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("reset.mealy", mealy_out, 1'b0);
            checkOutput("reset.moore", moore_out, 1'b0);
        end

        @(negedge clk);
        in  = 1'b0;
        rst = 1'b1;

        // Basic: 1,0,1,1 then flush zeros.
        applyStimulus("basic.b1", 1'b1, 1'b0, 1'b0);
        applyStimulus("basic.b2", 1'b0, 1'b0, 1'b0);
        applyStimulus("basic.b3", 1'b1, 1'b0, 1'b0);
        applyStimulus("basic.b4", 1'b1, 1'b1, 1'b0);
        applyStimulus("basic.f1", 1'b0, 1'b0, 1'b1);
        applyStimulus("basic.f2", 1'b0, 1'b0, 1'b0);

        // Overlap: 1,0,1,1,0,1,1 -> detections at bit 4 and bit 7.
        applyStimulus("ovl.b1", 1'b1, 1'b0, 1'b0);
        applyStimulus("ovl.b2", 1'b0, 1'b0, 1'b0);
        applyStimulus("ovl.b3", 1'b1, 1'b0, 1'b0);
        applyStimulus("ovl.b4", 1'b1, 1'b1, 1'b0);
        applyStimulus("ovl.b5", 1'b0, 1'b0, 1'b1);
        applyStimulus("ovl.b6", 1'b1, 1'b0, 1'b0);
        applyStimulus("ovl.b7", 1'b1, 1'b1, 1'b0);
        applyStimulus("ovl.f1", 1'b0, 1'b0, 1'b1);
        applyStimulus("ovl.f2", 1'b0, 1'b0, 1'b0);

        // Negative: 0,0,1,0 never detects.
        applyStimulus("neg.b1", 1'b0, 1'b0, 1'b0);
        applyStimulus("neg.b2", 1'b0, 1'b0, 1'b0);
        applyStimulus("neg.b3", 1'b1, 1'b0, 1'b0);
        applyStimulus("neg.b4", 1'b0, 1'b0, 1'b0);
        applyStimulus("neg.f1", 1'b0, 1'b0, 1'b0);

        // Reset mid-sequence: 1,0,1 then reset, then 1 must not detect.
        applyStimulus("rstmid.b1", 1'b1, 1'b0, 1'b0);
        applyStimulus("rstmid.b2", 1'b0, 1'b0, 1'b0);
        applyStimulus("rstmid.b3", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in  = 1'b1;
        rst = 1'b0;
        #1;
        checkOutput("rstmid.inrst.mealy", mealy_out, 1'b0);
        checkOutput("rstmid.inrst.moore", moore_out, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstmid.release.mealy", mealy_out, 1'b0);
        checkOutput("rstmid.release.moore", moore_out, 1'b0);
        applyStimulus("rstmid.f1", 1'b0, 1'b0, 1'b0);
        applyStimulus("rstmid.f2", 1'b0, 1'b0, 1'b0);
        applyStimulus("rstmid.f3", 1'b0, 1'b0, 1'b0);

        // Noisy start: 1,1,0,1,1 -> single detection at bit 5. Before bit 5
        // settles, 'in' dips to 0 to show the combinational Mealy path.
        applyStimulus("noisy.b1", 1'b1, 1'b0, 1'b0);
        applyStimulus("noisy.b2", 1'b1, 1'b0, 1'b0);
        applyStimulus("noisy.b3", 1'b0, 1'b0, 1'b0);
        applyStimulus("noisy.b4", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in = 1'b0;
        #1;
        checkOutput("noisy.dip.mealy", mealy_out, expMealy(1'b0, 1'b0));
        checkOutput("noisy.dip.moore", moore_out, 1'b0);
        #1;
        in = 1'b1;
        #1;
        checkOutput("noisy.b5.mealy", mealy_out, expMealy(1'b1, 1'b0));
        checkOutput("noisy.b5.moore", moore_out, 1'b0);
        applyStimulus("noisy.f1", 1'b0, 1'b0, 1'b1);
        applyStimulus("noisy.f2", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mealy_moore_1011.md
MEALY_MOORE_1011 -- requirements
Module: mealy_moore_1011

Interface
REQ-001 Parameters: none; behaviour is fixed at the 4-bit pattern 1011.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  clock; all state registers update on the rising edge.
REQ-004 rst  input  1  asynchronous active-low reset; 0 = reset, 1 = run.
REQ-005 in  input  1  serial data bit, one bit per clk cycle, sampled on the rising edge.
REQ-006 mealy_out  output  1  detection flag from the Mealy machine.
REQ-007 moore_out  output  1  detection flag from the Moore machine.

Function
REQ-008 The block SHALL contain two independent overlapping 1011 detectors, a Mealy FSM and a Moore FSM, both driven by the same in, clk and rst.
REQ-009 Mealy states SHALL be M0 (idle), M1 ("1"), M2 ("10") and M3 ("101"), using 2-bit binary encoding.
REQ-010 Mealy transitions (in=0 / in=1) SHALL be: M0->M0/M1; M1->M2/M1; M2->M0/M3; M3->M2/M1.
REQ-011 mealy_out SHALL be 1 exactly when state=M3 and in=1, and 0 otherwise (combinational, same cycle as the 4th bit).
REQ-012 Moore states SHALL be S0, S1, S2, S3 and S4 ("1011"), using 3-bit binary encoding; unused codes SHALL return to S0 on the next edge.
REQ-013 Moore transitions (in=0 / in=1) SHALL be: S0->S0/S1; S1->S2/S1; S2->S0/S3; S3->S2/S4; S4->S2/S1.
REQ-014 moore_out SHALL be 1 exactly when state=S4, as a function of state only, so it asserts for one full cycle after the edge that samples the 4th bit.
REQ-015 Overlap: the trailing "1" of a detected 1011 SHALL count as the first bit of the next pattern, so 1011011 produces two detections.
REQ-016 in changing mid-cycle SHALL affect only mealy_out combinationally (unless REQ-021 applies); state changes SHALL occur only at rising edges.

Reset
REQ-017 While rst=0, both FSMs SHALL be held in M0/S0 regardless of clk and in.
REQ-018 During reset, mealy_out=0 and moore_out=0.
REQ-019 Reset applied mid-sequence SHALL discard partial matches; detection SHALL restart from a fresh 1.
REQ-020 Release of rst SHALL take effect at the first rising edge after rst goes to 1.

Configuration
REQ-021 MEALY_REG_OUT_EN defined: mealy_out SHALL be taken from a flop clocked on clk, loaded each edge with (state==M3 && in) and cleared asynchronously by rst, making mealy_out cycle-identical to moore_out.
REQ-022 MEALY_REG_OUT_EN undefined: mealy_out SHALL be combinational per REQ-011, and moore_out SHALL be unchanged in both builds.

Verification
REQ-023 Basic: reset, then in=1,0,1,1 on successive edges -> mealy_out=1 during the 4th bit cycle; moore_out=1 for the cycle after the 4th edge; both otherwise 0.
REQ-024 Overlap: in=1,0,1,1,0,1,1 -> exactly two pulses on each output, at bit 4 and bit 7.
REQ-025 Negative: in=0,0,1,0 from idle -> mealy_out and moore_out stay 0 throughout.
REQ-026 Reset mid-sequence: in=1,0,1, then rst=0 for one cycle, then in=1 -> no detection on either output.
REQ-027 Noisy start: in=1,1,0,1,1 -> single detection at bit 5 on both outputs; none earlier.
REQ-028 Macro: rerun REQ-023 with MEALY_REG_OUT_EN defined -> mealy_out equals moore_out on every cycle.
